io_bus_ctrl: RTL and testbench
==============================

IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 Parameter NUM_DEV, 4, number of memory-mapped peripheral channels (1-8).
REQ-002 Parameter ADDR_W, 16, CPU address width.
REQ-003 Parameter DATA_W, 8, data width.
REQ-004 Parameter WAIT_W, 3, width of per-channel wait-state field.
REQ-005 Parameter TIMEOUT, 15, cpu_clken strobes allowed in ack mode before forced completion.
REQ-006 Parameter OPEN_BUS, 8'hFF, read data returned on timeout.
REQ-007 Ports, listed as name, direction, width, meaning:
- sys_clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_clken  in  1  CPU cycle strobe.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_dout  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_din  out  DATA_W  read data to CPU.
- cpu_ready  out  1  CPU ready; low stalls the CPU.
- dev_base  in  NUM_DEV*ADDR_W  per-channel base address.
- dev_mask  in  NUM_DEV*ADDR_W  per-channel compare mask.
- dev_wait  in  NUM_DEV*WAIT_W  per-channel wait states; all-ones selects ack mode.
- dev_rdata  in  NUM_DEV*DATA_W  per-channel read data.
- dev_ack  in  NUM_DEV  per-channel early completion.
- dev_cs  out  NUM_DEV  one-hot channel select.
- dev_rd  out  NUM_DEV  one-cycle read strobe.
- dev_wr  out  NUM_DEV  one-cycle write strobe.
- dev_wdata  out  DATA_W  write data, equal to cpu_dout.
- ram_cs  out  1  default target selected.
- ram_rd  out  1  equal to ram_cs.
- ram_wr  out  1  equal to cpu_we & ram_cs.
- ram_dout  in  DATA_W  RAM read data.
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky timeout flag.

Function
REQ-008 Channel i SHALL hit when ((cpu_addr ^ base_i) & mask_i) == 0; the lowest-index hit wins; with no hit, ram_cs=1.
REQ-009 FSM states SHALL be IDLE, WAIT, ACKW; counter cnt is WAIT_W bits, or wide enough for TIMEOUT if that is larger.
REQ-010 IDLE + cpu_clken + (RAM or channel with wait=0): completion in the same cycle; cpu_ready=1; the strobe fires for that one cycle; state stays IDLE.
REQ-011 IDLE + cpu_clken + channel with wait W (0 < W < all-ones): cpu_ready=0 combinationally; dev_rd/dev_wr pulse that cycle only; channel index is latched; cnt=W; state goes to WAIT.
REQ-012 WAIT: cnt SHALL decrement on each cpu_clken; cpu_ready=0 until the cpu_clken on which cnt==1 or dev_ack[sel]=1. That cycle is the completion cycle: cpu_ready=1, then state goes to IDLE. Result: W stall strobes, ready on strobe W+1.
REQ-013 IDLE entry into an ack-mode channel: same as REQ-011, but cnt=TIMEOUT and state goes to ACKW.
REQ-014 ACKW: completion on the cpu_clken with dev_ack[sel]=1, cpu_din=dev_rdata[sel]. Otherwise cnt decrements per strobe. At cnt==0: forced completion, cpu_din=OPEN_BUS, timeout_err set.
REQ-015 cpu_din SHALL be combinational: the selected channel's dev_rdata, or ram_dout for RAM, or OPEN_BUS on forced completion.
REQ-016 dev_cs SHALL follow the decode in IDLE and be held on the latched channel in WAIT/ACKW.
REQ-017 dev_ack SHALL be ignored outside WAIT/ACKW and for non-selected channels.
REQ-018 err_clr SHALL clear timeout_err; if clear and set occur in the same cycle, set wins.
REQ-019 With cpu_clken=0 in IDLE: strobes are 0 and cpu_ready=1.

Reset
REQ-020 reset SHALL force IDLE asynchronously, including mid-WAIT/ACKW, and clear cnt, the latched index and timeout_err. Outputs then: dev_rd=dev_wr=0, cpu_ready=1; dev_cs/ram_cs reflect the combinational decode.

Verification
REQ-021 dev0 base D010, mask FFFE, wait 0; read D011 -> dev_cs=0001, dev_rd[0] 1-cycle pulse, cpu_din=dev_rdata0, cpu_ready=1, ram_cs=0.
REQ-022 dev1 base D012, mask FFFE, wait 3; write 8'h41 to D012 -> cpu_ready low for 3 strobes, one dev_wr[1] pulse, dev_wdata=41, ready high on strobe 4.
REQ-023 dev0 base D000, mask F000 and dev2 base D010, mask FFF0; access D015 -> dev_cs=0001.
REQ-024 dev3 wait 7 (ack mode): ack on strobe 5 -> completes on strobe 5. No ack -> completes after 15 strobes with cpu_din=FF and timeout_err=1; err_clr -> 0.
REQ-025 reset pulse during WAIT -> IDLE immediately, cpu_ready=1; the next access decodes normally.
REQ-026 Address 1234 with cpu_we=1 -> ram_cs=ram_rd=ram_wr=1, cpu_ready=1. Read -> cpu_din=ram_dout.

Source files
------------

// File: rtl/io_bus_ctrl.sv
// CPU bus decoder: zero-wait targets complete in the strobe cycle, wait-state channels stall cpu_ready W strobes,
// ack-mode channels stall until dev_ack or timeout; backpressure is cpu_ready low, counted in cpu_clken strobes.
module io_bus_ctrl #(
   parameter int                NUM_DEV  = 4,
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 8,
   parameter int                WAIT_W   = 3,
   parameter int                TIMEOUT  = 15,
   parameter logic [DATA_W-1:0] OPEN_BUS = 8'hFF
) (
   input  logic                      sys_clock,
   input  logic                      reset,
   input  logic                      cpu_clken,
   input  logic [ADDR_W-1:0]         cpu_addr,
   input  logic [DATA_W-1:0]         cpu_dout,
   input  logic                      cpu_we,
   output logic [DATA_W-1:0]         cpu_din,
   output logic                      cpu_ready,
   input  logic [NUM_DEV*ADDR_W-1:0] dev_base,
   input  logic [NUM_DEV*ADDR_W-1:0] dev_mask,
   input  logic [NUM_DEV*WAIT_W-1:0] dev_wait,
   input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
   input  logic [NUM_DEV-1:0]        dev_ack,
   output logic [NUM_DEV-1:0]        dev_cs,
   output logic [NUM_DEV-1:0]        dev_rd,
   output logic [NUM_DEV-1:0]        dev_wr,
   output logic [DATA_W-1:0]         dev_wdata,
   output logic                      ram_cs,
   output logic                      ram_rd,
   output logic                      ram_wr,
   input  logic [DATA_W-1:0]         ram_dout,
   input  logic                      err_clr,
   output logic                      timeout_err
);

   localparam int SEL_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam int CNT_W = (WAIT_W > TO_W) ? WAIT_W : TO_W;

   typedef enum logic [1:0] {IDLE, WAIT, ACKW} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [SEL_W-1:0]  sel_idx;

   logic [DATA_W-1:0] rdata_a [NUM_DEV];
   logic [WAIT_W-1:0] wait_a  [NUM_DEV];

   logic              dec_hit;
   logic [SEL_W-1:0]  dec_idx;
   logic [WAIT_W-1:0] dec_wait;
   logic              dec_slow;
   logic              dec_ackm;
   logic              ack_sel;
   logic              cnt_one;
   logic              cnt_zero;
   logic              forced;

   for (genvar g = 0; g < NUM_DEV; g++) begin : g_unpack
      assign rdata_a[g] = dev_rdata[g*DATA_W +: DATA_W];
      assign wait_a[g]  = dev_wait[g*WAIT_W +: WAIT_W];
   end

   // Scan from the top so the lowest-index hit is the one left standing.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         if (((cpu_addr ^ dev_base[i*ADDR_W +: ADDR_W]) & dev_mask[i*ADDR_W +: ADDR_W]) == '0) begin
            dec_hit = 1'b1;
            dec_idx = SEL_W'(i);
         end
      end
   end

   assign dec_wait = wait_a[dec_idx];
   assign dec_slow = dec_hit & (dec_wait != '0);
   assign dec_ackm = (dec_wait == '1);
   assign ack_sel  = dev_ack[sel_idx];
   assign cnt_one  = (cnt == CNT_W'(1));
   assign cnt_zero = (cnt == '0);
   assign forced   = (state == ACKW) & cpu_clken & ~ack_sel & cnt_zero;

   always_comb begin
      cpu_ready = 1'b1;
      cpu_din   = ram_dout;
      dev_cs    = '0;
      dev_rd    = '0;
      dev_wr    = '0;
      ram_cs    = 1'b0;
      case (state)
         IDLE: begin
            if (dec_hit) begin
               dev_cs[dec_idx] = 1'b1;
               cpu_din         = rdata_a[dec_idx];
               if (cpu_clken) begin
                  dev_rd[dec_idx] = ~cpu_we;
                  dev_wr[dec_idx] = cpu_we;
                  cpu_ready       = ~dec_slow;
               end
            end else begin
               ram_cs = 1'b1;
            end
         end
         WAIT: begin
            dev_cs[sel_idx] = 1'b1;
            cpu_din         = rdata_a[sel_idx];
            cpu_ready       = cpu_clken & (cnt_one | ack_sel);
         end
         ACKW: begin
            dev_cs[sel_idx] = 1'b1;
            cpu_din         = forced ? OPEN_BUS : rdata_a[sel_idx];
            cpu_ready       = cpu_clken & (ack_sel | cnt_zero);
         end
         default: begin
            cpu_ready = 1'b1;
         end
      endcase
   end

   assign dev_wdata = cpu_dout;
   assign ram_rd    = ram_cs;
   assign ram_wr    = cpu_we & ram_cs;

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         sel_idx     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (forced) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (cpu_clken && dec_slow) begin
                  sel_idx <= dec_idx;
                  if (dec_ackm) begin
                     cnt   <= CNT_W'(TIMEOUT);
                     state <= ACKW;
                  end else begin
                     cnt   <= CNT_W'(dec_wait);
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cpu_clken) begin
                  if (cnt_one || ack_sel) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
            end
            ACKW: begin
               if (cpu_clken) begin
                  if (ack_sel || cnt_zero) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: vector table through a completion scoreboard plus reset/error/decode sequences.
module tb_io_bus_ctrl;

   localparam int NUM_DEV = 4;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 8;
   localparam int WAIT_W  = 3;

   logic                      sys_clock = 1'b0;
   logic                      reset;
   logic                      cpu_clken;
   logic [ADDR_W-1:0]         cpu_addr;
   logic [DATA_W-1:0]         cpu_dout;
   logic                      cpu_we;
   logic [DATA_W-1:0]         cpu_din;
   logic                      cpu_ready;
   logic [NUM_DEV*ADDR_W-1:0] dev_base;
   logic [NUM_DEV*ADDR_W-1:0] dev_mask;
   logic [NUM_DEV*WAIT_W-1:0] dev_wait;
   logic [NUM_DEV*DATA_W-1:0] dev_rdata;
   logic [NUM_DEV-1:0]        dev_ack;
   logic [NUM_DEV-1:0]        dev_cs;
   logic [NUM_DEV-1:0]        dev_rd;
   logic [NUM_DEV-1:0]        dev_wr;
   logic [DATA_W-1:0]         dev_wdata;
   logic                      ram_cs;
   logic                      ram_rd;
   logic                      ram_wr;
   logic [DATA_W-1:0]         ram_dout;
   logic                      err_clr;
   logic                      timeout_err;

   io_bus_ctrl dut (
      .sys_clock(sys_clock), .reset(reset), .cpu_clken(cpu_clken), .cpu_addr(cpu_addr),
      .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_ready(cpu_ready),
      .dev_base(dev_base), .dev_mask(dev_mask), .dev_wait(dev_wait), .dev_rdata(dev_rdata),
      .dev_ack(dev_ack), .dev_cs(dev_cs), .dev_rd(dev_rd), .dev_wr(dev_wr),
      .dev_wdata(dev_wdata), .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr),
      .ram_dout(ram_dout), .err_clr(err_clr), .timeout_err(timeout_err)
   );

   always #5 sys_clock = ~sys_clock;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  dout;
      logic        gap;
      int          ack_at;
      logic [3:0]  ack_mask;
      logic [3:0]  exp_cs;
      logic        exp_ram;
      logic        exp_ramwr;
      logic [7:0]  exp_din;
      int          exp_strobes;
      int          exp_rd;
      int          exp_wr;
      logic        exp_err;
   } vec_t;

   vec_t vecs [12];
   vec_t sb [$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one CPU access strobe by strobe and compares against the record popped at completion.
   task automatic run_vec(input string tag, input vec_t v);
      vec_t       e;
      int         strobe, rd_n, wr_n, done_strobe;
      logic [3:0] cs0, cs_done;
      logic       ram0, ramrd0, ramwr0, done;
      logic [7:0] din_c, wd_c;
      sb.push_back(v);
      strobe = 0; rd_n = 0; wr_n = 0; done_strobe = 0; done = 1'b0;
      cs0 = '0; cs_done = '0; ram0 = 1'b0; ramrd0 = 1'b0; ramwr0 = 1'b0; din_c = '0; wd_c = '0;
      cpu_addr = v.addr; cpu_we = v.we; cpu_dout = v.dout;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         cpu_clken = !(v.gap && (cyc % 2 == 1));
         if (cpu_clken) strobe++;
         dev_ack = (cpu_clken && strobe == v.ack_at) ? v.ack_mask : 4'b0;
         @(negedge sys_clock);
         rd_n += $countones(dev_rd);
         wr_n += $countones(dev_wr);
         if (cyc == 0) begin
            cs0 = dev_cs; ram0 = ram_cs; ramrd0 = ram_rd; ramwr0 = ram_wr;
         end
         if (cpu_clken && cpu_ready) begin
            done = 1'b1; done_strobe = strobe; din_c = cpu_din; wd_c = dev_wdata; cs_done = dev_cs;
         end
         @(posedge sys_clock);
         #1;
      end
      cpu_clken = 1'b0;
      dev_ack   = '0;
      e = sb.pop_front();
      if (!done) begin
         n_checks++;
         n_err++;
         $display("FAIL %s completion: no cpu_ready within 64 cycles, required strobe %0d", tag, e.exp_strobes);
      end else begin
         check({tag, " dev_cs"}, 32'(cs0), 32'(e.exp_cs));
         check({tag, " dev_cs_held"}, 32'(cs_done), 32'(e.exp_cs));
         check({tag, " ram_cs"}, 32'(ram0), 32'(e.exp_ram));
         check({tag, " ram_rd"}, 32'(ramrd0), 32'(e.exp_ram));
         check({tag, " ram_wr"}, 32'(ramwr0), 32'(e.exp_ramwr));
         check({tag, " cpu_din"}, 32'(din_c), 32'(e.exp_din));
         check({tag, " dev_wdata"}, 32'(wd_c), 32'(e.dout));
         check({tag, " ready_strobe"}, 32'(done_strobe), 32'(e.exp_strobes));
         check({tag, " rd_pulses"}, 32'(rd_n), 32'(e.exp_rd));
         check({tag, " wr_pulses"}, 32'(wr_n), 32'(e.exp_wr));
         check({tag, " timeout_err"}, 32'(timeout_err), 32'(e.exp_err));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t ov;
      //           addr      we    dout  gap ack ackm     cs       ram  rwr  din    stb rd wr err
      vecs[0]  = '{16'hD011, 1'b0, 8'h00, 1'b0, 0, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'hA0, 1, 1, 0, 1'b0};
      vecs[1]  = '{16'hD012, 1'b1, 8'h41, 1'b0, 0, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'hB1, 4, 0, 1, 1'b0};
      vecs[2]  = '{16'hD013, 1'b0, 8'h00, 1'b1, 0, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'hB1, 4, 1, 0, 1'b0};
      vecs[3]  = '{16'hD025, 1'b0, 8'h00, 1'b0, 0, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'hC2, 2, 1, 0, 1'b0};
      vecs[4]  = '{16'hD031, 1'b0, 8'h00, 1'b0, 5, 4'b1000, 4'b1000, 1'b0, 1'b0, 8'hD3, 5, 1, 0, 1'b0};
      vecs[5]  = '{16'hD012, 1'b0, 8'h00, 1'b0, 2, 4'b0010, 4'b0010, 1'b0, 1'b0, 8'hB1, 2, 1, 0, 1'b0};
      vecs[6]  = '{16'hD012, 1'b0, 8'h00, 1'b0, 2, 4'b0001, 4'b0010, 1'b0, 1'b0, 8'hB1, 4, 1, 0, 1'b0};
      vecs[7]  = '{16'hD012, 1'b0, 8'h00, 1'b0, 1, 4'b0010, 4'b0010, 1'b0, 1'b0, 8'hB1, 4, 1, 0, 1'b0};
      vecs[8]  = '{16'h1234, 1'b1, 8'h77, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h5A, 1, 0, 0, 1'b0};
      vecs[9]  = '{16'h1234, 1'b0, 8'h00, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h5A, 1, 0, 0, 1'b0};
      vecs[10] = '{16'hD03F, 1'b0, 8'h00, 1'b0, 0, 4'b0000, 4'b1000, 1'b0, 1'b0, 8'hFF, 17, 1, 0, 1'b1};
      vecs[11] = '{16'hD031, 1'b0, 8'h00, 1'b1, 3, 4'b1000, 4'b1000, 1'b0, 1'b0, 8'hD3, 3, 1, 0, 1'b1};

      reset = 1'b1; cpu_clken = 1'b0; cpu_addr = '0; cpu_dout = '0; cpu_we = 1'b0;
      dev_ack = '0; err_clr = 1'b0; ram_dout = 8'h5A;
      dev_base  = {16'hD030, 16'hD020, 16'hD012, 16'hD010};
      dev_mask  = {16'hFFF0, 16'hFFF0, 16'hFFFE, 16'hFFFE};
      dev_wait  = {3'd7, 3'd1, 3'd3, 3'd0};
      dev_rdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

      #12;
      check("reset cpu_ready", 32'(cpu_ready), 32'd1);
      check("reset dev_rd", 32'(dev_rd), 32'd0);
      check("reset dev_wr", 32'(dev_wr), 32'd0);
      check("reset timeout_err", 32'(timeout_err), 32'd0);
      check("reset ram_cs", 32'(ram_cs), 32'd1);
      reset = 1'b0;
      @(posedge sys_clock);
      #1;

      for (int i = 0; i < 12; i++) run_vec($sformatf("v%0d", i), vecs[i]);

      // Idle with no strobe: decode visible, no strobes, ready high; err_clr drops the sticky flag.
      cpu_addr = 16'hD012; cpu_we = 1'b0; err_clr = 1'b1;
      @(negedge sys_clock);
      check("idle cpu_ready", 32'(cpu_ready), 32'd1);
      check("idle dev_rd", 32'(dev_rd), 32'd0);
      check("idle dev_cs", 32'(dev_cs), 32'b0010);
      @(posedge sys_clock);
      #1;
      err_clr = 1'b0;
      check("err_clr", 32'(timeout_err), 32'd0);

      // err_clr held across a forced completion: the set must win.
      err_clr = 1'b1;
      run_vec("set_wins", vecs[10]);
      err_clr = 1'b0;

      // Asynchronous reset while stalled in WAIT.
      cpu_addr = 16'hD012; cpu_we = 1'b0; cpu_clken = 1'b1;
      @(posedge sys_clock);
      #1;
      cpu_clken = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check("rst_wait cpu_ready", 32'(cpu_ready), 32'd1);
      check("rst_wait timeout_err", 32'(timeout_err), 32'd0);
      check("rst_wait dev_rd", 32'(dev_rd), 32'd0);
      @(negedge sys_clock);
      reset = 1'b0;
      @(posedge sys_clock);
      #1;
      run_vec("post_rst0", vecs[0]);
      run_vec("post_rst1", vecs[1]);

      // Overlapping windows: dev0 covers D000-DFFF, dev2 covers D010-D01F, lowest index wins.
      dev_base[0*16 +: 16] = 16'hD000; dev_mask[0*16 +: 16] = 16'hF000;
      dev_base[2*16 +: 16] = 16'hD010; dev_mask[2*16 +: 16] = 16'hFFF0;
      ov = '{16'hD015, 1'b0, 8'h00, 1'b0, 0, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'hA0, 1, 1, 0, 1'b0};
      run_vec("overlap", ov);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
